htpa_spi_engine: RTL and testbench
==================================

// Module: htpa_spi_engine
// PURPOSE
//  SPI master (mode 0) shared by the HTPA sensor matrix and the 25xx SPI EEPROM.
//  Shifts a command/address/data word out MSB-first on MOSI and exports the TX bit count.
//  The downstream MOSI-stop decoder drives stop_mosi back. On stop_mosi, a read ends TX
//  and clocks rx_len bits in from MISO; a write ends the transaction.
// PARAMETERS
//  CLK_DIV  2  clk cycles per SCLK half-period; minimum 2
//  CS_GAP   4  clk cycles CS stays high after a transaction before done
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   transaction request; sampled only in IDLE
//  rd           in   1   1 = read transaction, 0 = write
//  eeprom_sel   in   1   1 = EEPROM, 0 = matrix
//  tx_word      in   40  bits to send; tx_word[39] goes first
//  rx_len       in   6   read bits, 0..32 (>32 clamps to 32; ignored when rd=0)
//  stop_mosi    in   1   from the MOSI-stop decoder; combinational on bit_cnt/rd_l/opcode/eeprom_cs
//  bit_cnt      out  6   TX bits completed in this transaction
//  rd_l         out  1   latched rd
//  opcode       out  8   latched tx_word[39:32]
//  eeprom_cs    out  1   latched eeprom_sel
//  spi_sclk     out  1   SPI clock; idles low
//  spi_mosi     out  1   SPI data out
//  spi_miso     in   1   SPI data in
//  matrix_cs_n  out  1   matrix chip select, active low
//  eeprom_cs_n  out  1   EEPROM chip select, active low
//  busy         out  1   high from the accept cycle through the done cycle
//  done         out  1   one-cycle pulse at end of transaction
//  rx_data      out  32  received bits, right-justified; first bit lands highest
// BEHAVIOUR
//  Reset values:
//   - spi_sclk, spi_mosi, busy, done, bit_cnt, rd_l, opcode, eeprom_cs, rx_data = 0.
//   - Both cs_n = 1.
//  Reset asserted mid-transaction:
//   - Outputs go to reset values immediately; the FSM returns to IDLE.
//   - No done pulse is generated.
//  FSM states: IDLE, TX_LO, TX_HI, RX_LO, RX_HI, HOLD, GAP. Each state except IDLE and GAP lasts CLK_DIV cycles.
//  IDLE -> TX_LO when start=1:
//   - Latch rd, eeprom_sel, tx_word and clamped rx_len.
//   - Clear bit_cnt and rx_data.
//   - Assert the selected cs_n low; drive spi_mosi = tx_word[39]; set busy.
//  TX_LO -> TX_HI: spi_sclk rises.
//  TX_HI end: spi_sclk falls, bit_cnt increments, next state is TX_LO.
//  First cycle of each TX_LO after bit_cnt >= 1 evaluates stop_mosi, or bit_cnt == 40:
//   - 0: MOSI = next tx bit; stay in TX.
//   - 1 and rd_l=1 and rx_len>0: MOSI = 0; the state becomes RX_LO for the remainder of this half-period.
//   - 1 otherwise: MOSI = 0 -> HOLD.
//   - Forced stop at bit_cnt=40 is taken even if stop_mosi=0.
//  bit_cnt counts TX bits only; it holds during RX and HOLD and stays valid until the next start.
//  RX_LO -> RX_HI: spi_sclk rises; spi_miso is sampled on that cycle: rx_data <= {rx_data[30:0], miso}.
//  RX_HI end: spi_sclk falls. After rx_len samples -> HOLD, otherwise -> RX_LO.
//  HOLD: CS stays low for CLK_DIV cycles after the last falling edge.
//  GAP: cs_n high, CS_GAP cycles. In the last GAP cycle done=1, busy=1; the next cycle is IDLE with busy=0.
//  start is ignored while busy. start held high triggers a new transaction on the first IDLE cycle.
//  Only the latched chip select toggles; the other cs_n stays 1 throughout.
//  rx_data and the latched outputs hold until the next accepted start.
// TESTING
//  Bench models the stop decoder:
//   - Matrix: rd=1 stops at 8, rd=0 stops at 16.
//   - EEPROM read: opcode 5 stops at 8, else 24.
//   - EEPROM write: opcodes 4/5/6 stop at 8, else 40.
//  1. Matrix read, sel=0, rd=1, tx_word[39:32]=8'hA5, rx_len=16, MISO=16'h1234
//     -> 8 MOSI bits 10100101, 24 SCLK rising edges, rx_data=32'h1234, bit_cnt=8, one done.
//  2. EEPROM WREN, sel=1, rd=0, opcode=8'h06
//     -> eeprom_cs_n low for exactly 8 SCLK, no RX, matrix_cs_n stays 1, bit_cnt=8.
//  3. EEPROM write, opcode=8'h02, addr=16'h0010, data=16'hBEEF
//     -> 40 SCLK, MOSI sequence equals tx_word, bit_cnt=40.
//  4. EEPROM read, opcode=8'h03, rx_len=16
//     -> 24 TX + 16 RX edges, MOSI=0 during RX.
//     Also: decoder stub tied to stop_mosi=0 -> forced stop at bit_cnt=40.
//  5. start pulsed during a transaction -> ignored.
//     Also: rst_n low mid-TX -> cs_n=1, sclk=0, busy=0 in the same cycle; no done.
//  6. start held high -> second CS falls no earlier than CS_GAP+1 cycles after the first CS rises.

Source files
------------

// File: rtl/htpa_spi_engine.sv
// SPI mode-0 master shared by the HTPA sensor matrix and the 25xx EEPROM.
// Shifts tx_word out MSB-first until the external MOSI-stop decoder raises stop_mosi
// (or 40 bits are sent), then optionally clocks rx_len bits in from MISO.
// Ports: clk/rst_n; start/rd/eeprom_sel/tx_word/rx_len request a transaction;
// stop_mosi comes back from the decoder, which watches bit_cnt/rd_l/opcode/eeprom_cs;
// spi_* and the two cs_n drive the bus; busy/done/rx_data report status and result.
module htpa_spi_engine #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rd,
    input  logic        eeprom_sel,
    input  logic [39:0] tx_word,
    input  logic [5:0]  rx_len,
    input  logic        stop_mosi,
    output logic [5:0]  bit_cnt,
    output logic        rd_l,
    output logic [7:0]  opcode,
    output logic        eeprom_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        matrix_cs_n,
    output logic        eeprom_cs_n,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data
);
    localparam int unsigned TX_W    = 40;
    localparam int unsigned RX_W    = 32;
    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, TX_LO, TX_HI, RX_LO, RX_HI, HOLD, GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [39:0]      sh_q, sh_d;
    logic [5:0]       rx_len_q, rx_len_d;
    logic [5:0]       rx_cnt_q, rx_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             rd_l_q, rd_l_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             eeprom_cs_q, eeprom_cs_d;
    logic [31:0]      rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             matrix_cs_n_q, matrix_cs_n_d;
    logic             eeprom_cs_n_q, eeprom_cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_inc;
    logic             cs_act;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sh_q          <= '0;
            rx_len_q      <= '0;
            rx_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            rd_l_q        <= 1'b0;
            opcode_q      <= '0;
            eeprom_cs_q   <= 1'b0;
            rx_data_q     <= '0;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            matrix_cs_n_q <= 1'b1;
            eeprom_cs_n_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_q          <= sh_d;
            rx_len_q      <= rx_len_d;
            rx_cnt_q      <= rx_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            rd_l_q        <= rd_l_d;
            opcode_q      <= opcode_d;
            eeprom_cs_q   <= eeprom_cs_d;
            rx_data_q     <= rx_data_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            matrix_cs_n_q <= matrix_cs_n_d;
            eeprom_cs_n_q <= eeprom_cs_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; bus outputs are derived from the next state so they stay registered
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rx_len_d    = rx_len_q;
        rx_cnt_d    = rx_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        rd_l_d      = rd_l_q;
        opcode_d    = opcode_q;
        eeprom_cs_d = eeprom_cs_q;
        rx_data_d   = rx_data_q;
        mosi_d      = mosi_q;
        cnt_last    = (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_inc     = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = TX_LO;
                    cnt_d       = '0;
                    rd_l_d      = rd;
                    eeprom_cs_d = eeprom_sel;
                    opcode_d    = tx_word[39:32];
                    sh_d        = {tx_word[38:0], 1'b0};
                    rx_len_d    = (rx_len > 6'(RX_W)) ? 6'(RX_W) : rx_len;
                    bit_cnt_d   = '0;
                    rx_cnt_d    = '0;
                    rx_data_d   = '0;
                    mosi_d      = tx_word[39];
                end
            end
            TX_LO: begin
                cnt_d = cnt_last ? '0 : cnt_inc;
                if (cnt_last) begin
                    state_d = TX_HI;
                end
                // Decoder verdict is taken on the first low cycle after each completed bit
                if (cnt_q == '0 && bit_cnt_q != '0) begin
                    if (stop_mosi || bit_cnt_q == 6'(TX_W)) begin
                        mosi_d = 1'b0;
                        if (rd_l_q && rx_len_q != '0) begin
                            // Same low half-period continues as the first RX low phase
                            state_d = RX_LO;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end
                    end else begin
                        mosi_d = sh_q[39];
                        sh_d   = {sh_q[38:0], 1'b0};
                    end
                end
            end
            TX_HI: begin
                cnt_d = cnt_last ? '0 : cnt_inc;
                if (cnt_last) begin
                    state_d   = TX_LO;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            RX_LO: begin
                cnt_d = cnt_last ? '0 : cnt_inc;
                if (cnt_last) begin
                    state_d   = RX_HI;
                    rx_data_d = {rx_data_q[30:0], spi_miso};
                    rx_cnt_d  = rx_cnt_q + 6'd1;
                end
            end
            RX_HI: begin
                cnt_d = cnt_last ? '0 : cnt_inc;
                if (cnt_last) begin
                    state_d = (rx_cnt_q == rx_len_q) ? HOLD : RX_LO;
                end
            end
            HOLD: begin
                cnt_d = cnt_last ? '0 : cnt_inc;
                if (cnt_last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_act        = (state_d == TX_LO) || (state_d == TX_HI) || (state_d == RX_LO) ||
                        (state_d == RX_HI) || (state_d == HOLD);
        sclk_d        = (state_d == TX_HI) || (state_d == RX_HI);
        matrix_cs_n_d = !(cs_act && !eeprom_cs_d);
        eeprom_cs_n_d = !(cs_act && eeprom_cs_d);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == GAP) && (cnt_d == CNT_W'(CS_GAP - 1));
    end

    assign bit_cnt     = bit_cnt_q;
    assign rd_l        = rd_l_q;
    assign opcode      = opcode_q;
    assign eeprom_cs   = eeprom_cs_q;
    assign rx_data     = rx_data_q;
    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign matrix_cs_n = matrix_cs_n_q;
    assign eeprom_cs_n = eeprom_cs_n_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_htpa_spi_engine.sv
// Bench for htpa_spi_engine: models the MOSI-stop decoder and an SPI slave, predicts
// each transaction at bit level (stop point, MOSI bits, RX bits) and checks the bus
// every cycle plus the per-transaction result.
module tb_htpa_spi_engine;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rd;
    logic        eeprom_sel;
    logic [39:0] tx_word;
    logic [5:0]  rx_len;
    logic        stop_mosi;
    logic [5:0]  bit_cnt;
    logic        rd_l;
    logic [7:0]  opcode;
    logic        eeprom_cs;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        matrix_cs_n;
    logic        eeprom_cs_n;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;

    htpa_spi_engine #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .eeprom_sel(eeprom_sel),
        .tx_word(tx_word), .rx_len(rx_len), .stop_mosi(stop_mosi), .bit_cnt(bit_cnt),
        .rd_l(rd_l), .opcode(opcode), .eeprom_cs(eeprom_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .matrix_cs_n(matrix_cs_n),
        .eeprom_cs_n(eeprom_cs_n), .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          edge_cnt = 0;
    int          done_cnt = 0;
    int          fall_cnt = 0;
    int          cyc = 0;
    int          last_rise = 0;
    int          fall_gap = 0;
    int          mk;
    logic [39:0] mosi_cap = '0;
    logic        sclk_prev = 1'b0;
    logic        cs_low_prev = 1'b0;
    logic        cs_low;
    logic        exp_sel = 1'b0;
    int          exp_n = 0;
    int          exp_rxn = 0;
    logic [39:0] exp_word = '0;
    logic [31:0] exp_miso = '0;
    logic        stub_zero = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Stop decoder rules: bit count at which MOSI ends
    function automatic int stop_point(input logic sel, input logic r, input logic [7:0] op);
        if (!sel) return r ? 8 : 16;
        if (r) return (op == 8'h05) ? 8 : 24;
        return (op == 8'h04 || op == 8'h05 || op == 8'h06) ? 8 : 40;
    endfunction

    always_comb stop_mosi = !stub_zero && (int'(bit_cnt) == stop_point(eeprom_cs, rd_l, opcode));

    // Slave: the k-th RX clock presents exp_miso[rxn-1-k], so the word lands right-justified
    always_comb begin
        mk = edge_cnt - exp_n;
        spi_miso = 1'b0;
        if (mk >= 0 && mk < exp_rxn) spi_miso = exp_miso[exp_rxn - 1 - mk];
    end

    // Per-cycle bus monitor
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            cs_low = !matrix_cs_n || !eeprom_cs_n;
            if (cs_low && !cs_low_prev) begin
                edge_cnt = 0;
                mosi_cap = '0;
                fall_cnt++;
                fall_gap = cyc - last_rise;
            end
            if (!cs_low && cs_low_prev) last_rise = cyc;
            if (spi_sclk && !sclk_prev) begin
                if (edge_cnt < exp_n) begin
                    chk("mosi_tx_bit", 64'(spi_mosi), 64'(exp_word[39 - edge_cnt]));
                    mosi_cap = {mosi_cap[38:0], spi_mosi};
                end else begin
                    chk("mosi_rx_zero", 64'(spi_mosi), 64'd0);
                end
                edge_cnt++;
            end
            chk("other_cs_high", 64'(exp_sel ? matrix_cs_n : eeprom_cs_n), 64'd1);
            if (!busy) begin
                chk("idle_cs_high", 64'({matrix_cs_n, eeprom_cs_n}), 64'd3);
                chk("idle_sclk_low", 64'(spi_sclk), 64'd0);
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 64'(busy), 64'd1);
            end
            sclk_prev   = spi_sclk;
            cs_low_prev = cs_low;
        end else begin
            sclk_prev   = 1'b0;
            cs_low_prev = 1'b0;
        end
    end

    task automatic set_model(input logic sel, input logic r, input logic [39:0] w,
                             input logic [5:0] rl, input logic [31:0] mw, input logic stub);
        exp_sel   = sel;
        exp_word  = w;
        exp_miso  = mw;
        stub_zero = stub;
        exp_n     = stub ? 40 : stop_point(sel, r, w[39:32]);
        exp_rxn   = r ? ((rl > 6'd32) ? 32 : int'(rl)) : 0;
    endtask

    task automatic run_txn(input logic sel, input logic r, input logic [39:0] w,
                           input logic [5:0] rl, input logic [31:0] mw, input logic stub,
                           input logic poke);
        int          budget;
        int          base;
        logic [31:0] rx_exp;
        @(negedge clk);
        set_model(sel, r, w, rl, mw, stub);
        base       = done_cnt;
        eeprom_sel = sel;
        rd         = r;
        tx_word    = w;
        rx_len     = rl;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (done_cnt == base && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (poke && budget == 15) begin
                start      = 1'b1;
                rd         = ~r;
                eeprom_sel = ~sel;
                tx_word    = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
            end
            if (poke && budget == 16) start = 1'b0;
        end
        chk("done_timeout", 64'(budget < 3000), 64'd1);
        repeat (CS_GAP + 4) @(negedge clk);
        rx_exp = 32'(((64'd1 << exp_rxn) - 64'd1) & {32'd0, exp_miso});
        chk("sclk_edges", 64'(edge_cnt), 64'(exp_n + exp_rxn));
        chk("mosi_seq", 64'(mosi_cap), 64'(exp_word >> (40 - exp_n)));
        chk("bit_cnt", 64'(bit_cnt), 64'(exp_n));
        chk("rx_data", 64'(rx_data), 64'(rx_exp));
        chk("rd_l", 64'(rd_l), 64'(r));
        chk("opcode", 64'(opcode), 64'(w[39:32]));
        chk("eeprom_cs", 64'(eeprom_cs), 64'(sel));
        chk("done_once", 64'(done_cnt - base), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int          base;
        int          budget;
        logic [7:0]  op;
        logic [39:0] w;

        rst_n = 1'b0; start = 1'b0; rd = 1'b0; eeprom_sel = 1'b0;
        tx_word = '0; rx_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(spi_sclk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("rst_latched", 64'({rd_l, eeprom_cs, opcode}), 64'd0);
        chk("rst_rx_data", 64'(rx_data), 64'd0);
        chk("rst_cs_n", 64'({matrix_cs_n, eeprom_cs_n}), 64'd3);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Matrix read: 8 TX bits then 16 RX bits
        run_txn(1'b0, 1'b1, {8'hA5, 32'h1357_9BDF}, 6'd16, 32'h0000_1234, 1'b0, 1'b0);
        chk("t1_edges", 64'(edge_cnt), 64'd24);
        chk("t1_mosi", 64'(mosi_cap[7:0]), 64'hA5);
        chk("t1_rx", 64'(rx_data), 64'h1234);
        chk("t1_bits", 64'(bit_cnt), 64'd8);

        // EEPROM WREN
        run_txn(1'b1, 1'b0, {8'h06, 32'hFFFF_FFFF}, 6'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("t2_edges", 64'(edge_cnt), 64'd8);
        chk("t2_rx", 64'(rx_data), 64'd0);

        // EEPROM full-length write
        run_txn(1'b1, 1'b0, 40'h02_0010_BEEF, 6'd0, 32'h0, 1'b0, 1'b0);
        chk("t3_bits", 64'(bit_cnt), 64'd40);
        chk("t3_mosi", 64'(mosi_cap), 64'h02_0010_BEEF);

        // EEPROM read, then decoder stub forcing the 40-bit stop
        run_txn(1'b1, 1'b1, 40'h03_0020_0000, 6'd16, 32'h0000_C3A5, 1'b0, 1'b0);
        chk("t4_edges", 64'(edge_cnt), 64'd40);
        chk("t4_rx", 64'(rx_data), 64'hC3A5);
        run_txn(1'b1, 1'b1, 40'h03_0040_0000, 6'd8, 32'h0000_005A, 1'b1, 1'b0);
        chk("t4f_edges", 64'(edge_cnt), 64'd48);
        chk("t4f_bits", 64'(bit_cnt), 64'd40);

        // Clamp of rx_len above 32
        run_txn(1'b0, 1'b1, {8'h11, 32'h0}, 6'd63, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("clamp_rx", 64'(rx_data), 64'hDEAD_BEEF);

        // start pulsed mid-transaction
        run_txn(1'b0, 1'b0, {8'h3C, 32'h8421_0F0F}, 6'd0, 32'h0, 1'b0, 1'b1);

        // Reset mid-TX
        @(negedge clk);
        set_model(1'b0, 1'b1, {8'hA5, 32'h0}, 6'd16, 32'h1234, 1'b0);
        base = done_cnt;
        eeprom_sel = 1'b0; rd = 1'b1; tx_word = {8'hA5, 32'h0}; rx_len = 6'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", 64'({matrix_cs_n, eeprom_cs_n}), 64'd3);
        chk("arst_sclk", 64'(spi_sclk), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_bit_cnt", 64'(bit_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 64'(done_cnt - base), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);

        // start held high: back-to-back matrix writes
        @(negedge clk);
        set_model(1'b0, 1'b0, {8'h77, 32'h1234_5678}, 6'd0, 32'h0, 1'b0);
        base = fall_cnt;
        eeprom_sel = 1'b0; rd = 1'b0; tx_word = {8'h77, 32'h1234_5678}; rx_len = 6'd0;
        start = 1'b1;
        budget = 0;
        while (fall_cnt < base + 2 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        chk("held_timeout", 64'(budget < 2000), 64'd1);
        chk("held_gap", 64'(fall_gap >= int'(CS_GAP) + 1), 64'd1);
        base = done_cnt;
        budget = 0;
        while (done_cnt == base && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (CS_GAP + 4) @(negedge clk);
        chk("held_done2", 64'(done_cnt - base), 64'd1);
        chk("held_bits", 64'(bit_cnt), 64'd16);
        chk("held_edges", 64'(edge_cnt), 64'd16);
        chk("held_idle", 64'(busy), 64'd0);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            case ($urandom % 6)
                0: op = 8'h05;
                1: op = 8'h04;
                2: op = 8'h06;
                3: op = 8'h03;
                4: op = 8'h02;
                default: op = 8'($urandom);
            endcase
            w = {op, $urandom()};
            run_txn(1'($urandom % 2), 1'($urandom % 2), w, 6'($urandom % 64), $urandom(),
                    1'($urandom % 5 == 0), 1'($urandom % 4 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
